// File: rtl/vend_arbiter.sv
// rtl/vend_arbiter.sv - two-port coin collector sharing one round-robin arbitrated dispense mechanism
module vend_arbiter #(
  parameter int PRICE       = 2,
  parameter int DISP_CYCLES = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] coin_a,
  input  logic [1:0] coin_b,
  output logic       out,
  output logic [1:0] grant,
  output logic [1:0] change_a,
  output logic [1:0] change_b,
  output logic       busy
);

  typedef enum logic [1:0] {S_COLLECT, S_WAIT, S_VEND, S_REFUND} port_state_t;

  localparam logic [2:0] PRICE_C = 3'(PRICE);
  localparam logic [3:0] DISP_C  = 4'(DISP_CYCLES);

  port_state_t st     [2];
  port_state_t st_nxt [2];
  logic [2:0]  credit     [2];
  logic [2:0]  credit_nxt [2];
  logic [1:0]  chg     [2];
  logic [1:0]  chg_nxt [2];
  logic [1:0]  coin    [2];

  logic [3:0]  cnt, cnt_nxt;
  logic [1:0]  gnt_nxt;
  logic        ptr, ptr_nxt;        // 0: A wins a tie, 1: B wins a tie
  logic        mech_done, mech_free;
  logic [1:0]  elig, win;

  assign coin[0] = coin_a;
  assign coin[1] = coin_b;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        st[i]     <= S_COLLECT;
        credit[i] <= '0;
        chg[i]    <= '0;
      end
      grant <= '0;
      cnt   <= '0;
      ptr   <= 1'b0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        st[i]     <= st_nxt[i];
        credit[i] <= credit_nxt[i];
        chg[i]    <= chg_nxt[i];
      end
      grant <= gnt_nxt;
      cnt   <= cnt_nxt;
      ptr   <= ptr_nxt;
    end
  end

  always_comb begin
    mech_done = (grant != 2'b00) && (cnt == 4'd1);
    // the mechanism can be handed over on its final edge, so vends run back to back
    mech_free = (grant == 2'b00) || mech_done;

    for (int i = 0; i < 2; i++)
      elig[i] = (st[i] == S_WAIT) && (coin[i] != 2'b11);

    win = 2'b00;
    if (mech_free) begin
      if (elig == 2'b11) win = ptr ? 2'b10 : 2'b01;
      else               win = elig;
    end

    ptr_nxt = ptr;
    if (win[0])      ptr_nxt = 1'b1;
    else if (win[1]) ptr_nxt = 1'b0;

    gnt_nxt = grant;
    cnt_nxt = cnt;
    if (win != 2'b00) begin
      gnt_nxt = win;
      cnt_nxt = DISP_C;
    end else if (mech_done) begin
      gnt_nxt = 2'b00;
      cnt_nxt = 4'd0;
    end else if (grant != 2'b00) begin
      cnt_nxt = cnt - 4'd1;
    end

    for (int i = 0; i < 2; i++) begin
      st_nxt[i]     = st[i];
      credit_nxt[i] = credit[i];
      case (st[i])
        S_COLLECT: begin
          if (coin[i] == 2'b11) begin
            if (credit[i] != 3'd0) st_nxt[i] = S_REFUND;
          end else if (coin[i] != 2'b00) begin
            credit_nxt[i] = credit[i] + {1'b0, coin[i]};
            if (credit_nxt[i] >= PRICE_C) st_nxt[i] = S_WAIT;
          end
        end
        S_WAIT: begin
          if (coin[i] == 2'b11) st_nxt[i] = S_REFUND;
          else if (win[i])      st_nxt[i] = S_VEND;
        end
        S_VEND: begin
          if (mech_done) begin
            credit_nxt[i] = credit[i] - PRICE_C;
            st_nxt[i]     = (credit_nxt[i] != 3'd0) ? S_REFUND : S_COLLECT;
          end
        end
        default: begin
          credit_nxt[i] = credit[i] - ((credit[i] >= 3'd2) ? 3'd2 : 3'd1);
          if (credit_nxt[i] == 3'd0) st_nxt[i] = S_COLLECT;
        end
      endcase
      // change is registered from the coming state so it is nonzero exactly while in REFUND
      chg_nxt[i] = (st_nxt[i] == S_REFUND) ?
                   ((credit_nxt[i] >= 3'd2) ? 2'b10 : 2'b01) : 2'b00;
    end
  end

  always_comb begin
    out      = (grant != 2'b00);
    busy     = out;
    change_a = chg[0];
    change_b = chg[1];
  end

endmodule
